// File: rtl/fixpt_pkg.sv
// Shared definitions for the fixed-point requantisation blocks.
package fixpt_pkg;

    localparam int unsigned ROUND_TRUNC     = 0;
    localparam int unsigned ROUND_HALF_UP   = 1;
    localparam int unsigned ROUND_HALF_EVEN = 2;

    // Output range limits, held wide enough to compare against any aligned value.
    typedef struct packed {
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
    } lim_t;

    function automatic lim_t out_limits(input int unsigned width, input bit is_signed);
        lim_t lim;
        if (is_signed) begin
            lim.max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
            lim.min_v = -(64'sd1 <<< (width - 1));
        end else begin
            lim.max_v = (64'sd1 <<< width) - 64'sd1;
            lim.min_v = '0;
        end
        return lim;
    endfunction

endpackage

// File: rtl/fixpt_round.sv
// Combinational align-and-round: extends the input to W bits and moves it onto
// the output binary point, rounding away the dropped LSBs when narrowing.
module fixpt_round
    import fixpt_pkg::*;
#(
    parameter int          N_BITS_IN  = 8,
    parameter int          BIN_PT_IN  = 4,
    parameter int          BIN_PT_OUT = 1,
    parameter bit          SIGNED     = 1,
    parameter int unsigned ROUND_MODE = ROUND_HALF_EVEN,
    parameter int          W          = 13
) (
    input  logic [N_BITS_IN-1:0] din,
    output logic [W-1:0]         value
);

    localparam int SH  = BIN_PT_IN - BIN_PT_OUT;
    localparam int EXT = W - N_BITS_IN;

    logic [W-1:0] ext;

    // Unsigned inputs get zero MSBs, so ext[W-1] is a valid sign bit either way.
    assign ext = {{EXT{SIGNED ? din[N_BITS_IN-1] : 1'b0}}, din};

    if (SH > 0) begin : g_round
        localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);

        logic [SH-1:0] rem;
        logic [W-1:0]  flr;
        logic          inc;

        assign rem = ext[SH-1:0];
        assign flr = {{SH{ext[W-1]}}, ext[W-1:SH]};

        // Round increment from the dropped bits and the floor LSB.
        always_comb begin
            inc = 1'b0;
            case (ROUND_MODE)
                ROUND_HALF_UP:   inc = (rem >= HALF);
                ROUND_HALF_EVEN: inc = (rem > HALF) || ((rem == HALF) && flr[0]);
                default:         inc = 1'b0;
            endcase
        end

        assign value = flr + W'(inc);
    end else begin : g_pad
        assign value = ext << (-SH);
    end

endmodule

// File: rtl/fixpt_requant_stream.sv
// Two-stage valid/ready fixed-point requantiser with overflow flag and counter.
module fixpt_requant_stream
    import fixpt_pkg::*;
#(
    parameter int          N_BITS_IN  = 8,
    parameter int          BIN_PT_IN  = 4,
    parameter int          N_BITS_OUT = 4,
    parameter int          BIN_PT_OUT = 1,
    parameter bit          SIGNED     = 1,
    parameter int unsigned ROUND_MODE = ROUND_HALF_EVEN,
    parameter bit          SATURATE   = 1,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BITS_IN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [N_BITS_OUT-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_ovf,
    output logic [CNT_BITS-1:0]   ovf_cnt,
    input  logic                  ovf_clr
);

    localparam int   SH  = BIN_PT_IN - BIN_PT_OUT;
    localparam int   ASH = (SH < 0) ? -SH : SH;
    localparam int   W   = N_BITS_IN + ASH + 2;
    localparam lim_t LIM = out_limits(N_BITS_OUT, SIGNED);

    if (N_BITS_IN < 1 || N_BITS_OUT < 1) begin : g_bad_width
        $error("fixpt_requant_stream: N_BITS_IN and N_BITS_OUT must be >= 1");
    end
    if (W > 64 || N_BITS_OUT > 62) begin : g_too_wide
        $error("fixpt_requant_stream: aligned width exceeds the 64-bit range check");
    end

    logic                  advance;
    logic [W-1:0]          rounded;
    logic                  s1_valid_q;
    logic [W-1:0]          s1_value_q;
    logic signed [63:0]    wide;
    logic [N_BITS_OUT-1:0] sat_value;
    logic                  sat_ovf;
    logic [N_BITS_OUT-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  dout_ovf_q;
    logic [CNT_BITS-1:0]   ovf_cnt_q;
    logic                  out_xfer;

    // Single global advance: both stages move together whenever the output slot frees up.
    assign din_ready = !dout_valid_q || dout_ready;
    assign advance   = din_ready;
    assign out_xfer  = dout_valid_q && dout_ready;

    fixpt_round #(
        .N_BITS_IN  (N_BITS_IN),
        .BIN_PT_IN  (BIN_PT_IN),
        .BIN_PT_OUT (BIN_PT_OUT),
        .SIGNED     (SIGNED),
        .ROUND_MODE (ROUND_MODE),
        .W          (W)
    ) u_round (
        .din   (din),
        .value (rounded)
    );

    // Stage 1: capture the aligned, rounded value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_value_q <= '0;
        end else if (advance) begin
            s1_valid_q <= din_valid;
            s1_value_q <= rounded;
        end
    end

    assign wide = 64'($signed(s1_value_q));

    // Range check against the output limits; clamp or wrap on overflow.
    always_comb begin
        sat_ovf   = 1'b0;
        sat_value = wide[N_BITS_OUT-1:0];
        if (wide > LIM.max_v) begin
            sat_ovf = 1'b1;
            if (SATURATE) sat_value = LIM.max_v[N_BITS_OUT-1:0];
        end else if (wide < LIM.min_v) begin
            sat_ovf = 1'b1;
            if (SATURATE) sat_value = LIM.min_v[N_BITS_OUT-1:0];
        end
    end

    // Stage 2: output register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_ovf_q   <= 1'b0;
        end else if (advance) begin
            dout_valid_q <= s1_valid_q;
            dout_q       <= sat_value;
            dout_ovf_q   <= sat_ovf && s1_valid_q;
        end
    end

    // Saturating count of overflowed samples taken by downstream; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_cnt_q <= '0;
        end else if (out_xfer && dout_ovf_q && !(&ovf_cnt_q)) begin
            ovf_cnt_q <= ovf_cnt_q + CNT_BITS'(1);
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_ovf   = dout_ovf_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_fixpt_requant_stream.sv
// Bench for fixpt_requant_stream: scoreboard on the default instance plus
// directly checked instances with other rounding/overflow/alignment settings.
module tb_fixpt_requant_stream;

    typedef struct {
        logic [7:0] din;
        logic [3:0] dout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [3:0] dout;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Default instance (signed 8.4 -> 4.1, half-even, saturate)
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [3:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_ovf;
    logic [15:0] ovf_cnt;
    logic        ovf_clr = 1'b0;

    // Half-up instance
    logic [7:0]  hu_din = '0;
    logic        hu_valid = 1'b0;
    logic        hu_ready, hu_dv, hu_ovf;
    logic [3:0]  hu_dout;
    logic [15:0] hu_cnt;

    // Wrap instance
    logic [7:0]  wr_din = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready, wr_dv, wr_ovf;
    logic [3:0]  wr_dout;
    logic [15:0] wr_cnt;

    // Unsigned 4.4 -> 4.(-1) instance
    logic [3:0]  up_din = '0;
    logic        up_valid = 1'b0;
    logic        up_ready, up_dv, up_ovf;
    logic [3:0]  up_dout;
    logic [15:0] up_cnt;

    int   n_pass = 0;
    int   n_total = 0;
    int   rx_cnt = 0;
    exp_t sb[$];
    vec_t tbl[15];

    always #5 clk = ~clk;

    fixpt_requant_stream u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_ovf(dout_ovf),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    fixpt_requant_stream #(.ROUND_MODE(1)) u_hu (
        .clk(clk), .rst(rst), .din(hu_din), .din_valid(hu_valid), .din_ready(hu_ready),
        .dout(hu_dout), .dout_valid(hu_dv), .dout_ready(1'b1), .dout_ovf(hu_ovf),
        .ovf_cnt(hu_cnt), .ovf_clr(1'b0)
    );

    fixpt_requant_stream #(.SATURATE(0)) u_wr (
        .clk(clk), .rst(rst), .din(wr_din), .din_valid(wr_valid), .din_ready(wr_ready),
        .dout(wr_dout), .dout_valid(wr_dv), .dout_ready(1'b1), .dout_ovf(wr_ovf),
        .ovf_cnt(wr_cnt), .ovf_clr(1'b0)
    );

    fixpt_requant_stream #(
        .N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(4), .BIN_PT_OUT(-1), .SIGNED(0)
    ) u_up (
        .clk(clk), .rst(rst), .din(up_din), .din_valid(up_valid), .din_ready(up_ready),
        .dout(up_dout), .dout_valid(up_dv), .dout_ready(1'b1), .dout_ovf(up_ovf),
        .ovf_cnt(up_cnt), .ovf_clr(1'b0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    // Scoreboard monitor: every output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && dout_valid === 1'b1 && dout_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: actual=%0h required=none", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_dout", 32'(dout), 32'(e.dout));
                chk("sb_ovf", 32'(dout_ovf), 32'(e.ovf));
                rx_cnt++;
            end
        end
    end

    // Present one sample to the default instance and record its expected result on acceptance.
    task automatic send(input logic [7:0] d, input logic [3:0] e, input logic o);
        bit acc = 1'b0;
        din       = d;
        din_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            if (din_ready === 1'b1) begin
                acc = 1'b1;
                sb.push_back('{dout: e, ovf: o});
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: actual=no_accept required=accept din=%0h", d);
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One sample through a side instance: accept on the next edge, result two edges later.
    task automatic side(input int idx, input logic [7:0] d, input logic [3:0] e, input logic o,
                        input string nm);
        logic       v, ov;
        logic [3:0] q;
        case (idx)
            0: begin hu_din = d; hu_valid = 1'b1; end
            1: begin wr_din = d; wr_valid = 1'b1; end
            default: begin up_din = d[3:0]; up_valid = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        hu_valid = 1'b0;
        wr_valid = 1'b0;
        up_valid = 1'b0;
        @(posedge clk);
        #1;
        case (idx)
            0: begin v = hu_dv; q = hu_dout; ov = hu_ovf; end
            1: begin v = wr_dv; q = wr_dout; ov = wr_ovf; end
            default: begin v = up_dv; q = up_dout; ov = up_ovf; end
        endcase
        chk({nm, "_valid"}, 32'(v), 32'd1);
        chk(nm, 32'(q), 32'(e));
        chk({nm, "_ovf"}, 32'(ov), 32'(o));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        tbl[0]  = '{8'h14, 4'b0010, 1'b0};  // 2.5 -> even 2
        tbl[1]  = '{8'h1C, 4'b0100, 1'b0};  // 3.5 -> even 4
        tbl[2]  = '{8'hEC, 4'b1110, 1'b0};  // -2.5 -> -2
        tbl[3]  = '{8'h0C, 4'b0010, 1'b0};  // 1.5 -> 2
        tbl[4]  = '{8'h0E, 4'b0010, 1'b0};  // 1.75 -> 2
        tbl[5]  = '{8'h38, 4'b0111, 1'b0};  // exactly max
        tbl[6]  = '{8'h3C, 4'b0111, 1'b1};  // 7.5 rounds to 8 -> clamp
        tbl[7]  = '{8'hC0, 4'b1000, 1'b0};  // exactly min
        tbl[8]  = '{8'hBC, 4'b1000, 1'b0};  // -8.5 -> -8
        tbl[9]  = '{8'h00, 4'b0000, 1'b0};
        tbl[10] = '{8'hFF, 4'b0000, 1'b0};  // -0.125 -> 0
        tbl[11] = '{8'h13, 4'b0010, 1'b0};
        tbl[12] = '{8'h7F, 4'b0111, 1'b1};
        tbl[13] = '{8'h80, 4'b1000, 1'b1};
        tbl[14] = '{8'h30, 4'b0110, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_ovf", 32'(dout_ovf), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);

        // Latency: output appears on the second edge after acceptance
        send(8'h13, 4'b0010, 1'b0);
        din_valid = 1'b0;
        chk("lat_cycle1_valid", 32'(dout_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", 32'(dout_valid), 32'd1);
        chk("lat_cycle2_dout", 32'(dout), 32'b0010);
        chk("lat_cycle2_ovf", 32'(dout_ovf), 32'd0);
        idle(2);

        // Saturation at both limits
        send(8'h7F, 4'b0111, 1'b1);
        send(8'h80, 4'b1000, 1'b1);
        idle(4);
        chk("sat_ovf_cnt", 32'(ovf_cnt), 32'd2);

        // Back-to-back table stream
        foreach (tbl[i]) send(tbl[i].din, tbl[i].dout, tbl[i].ovf);
        idle(4);
        chk("tbl_ovf_cnt", 32'(ovf_cnt), 32'd5);
        chk("tbl_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: stall 5 cycles with three samples in the pipe
        base = rx_cnt;
        fork
            begin
                send(8'h10, 4'b0010, 1'b0);
                send(8'h20, 4'b0100, 1'b0);
                send(8'h30, 4'b0110, 1'b0);
                din_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                dout_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("bp_hold_valid", 32'(dout_valid), 32'd1);
                    chk("bp_hold_dout", 32'(dout), 32'b0010);
                    chk("bp_din_ready", 32'(din_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                dout_ready = 1'b1;
            end
        join
        idle(5);
        chk("bp_count", 32'(rx_cnt - base), 32'd3);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Counter: clear, run up to FFFE, then saturate
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
        for (int i = 0; i < 65534; i++) send(8'h7F, 4'b0111, 1'b1);
        idle(4);
        chk("cnt_fffe", 32'(ovf_cnt), 32'hFFFE);
        send(8'h7F, 4'b0111, 1'b1);
        send(8'h80, 4'b1000, 1'b1);
        idle(4);
        chk("cnt_ffff", 32'(ovf_cnt), 32'hFFFF);
        send(8'h7F, 4'b0111, 1'b1);
        idle(4);
        chk("cnt_hold_ffff", 32'(ovf_cnt), 32'hFFFF);

        // Clear coincident with an overflowed transfer
        send(8'h80, 4'b1000, 1'b1);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("clrx_valid", 32'(dout_valid), 32'd1);
        chk("clrx_ovf", 32'(dout_ovf), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("clrx_ovf_cnt", 32'(ovf_cnt), 32'd0);
        idle(3);

        // Reset with two samples in flight
        send(8'h7F, 4'b0111, 1'b1);
        idle(4);
        chk("pre_rst_ovf_cnt", 32'(ovf_cnt), 32'd1);
        send(8'h10, 4'b0010, 1'b0);
        send(8'h20, 4'b0100, 1'b0);
        din_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_dout_valid", 32'(dout_valid), 32'd0);
        chk("mrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        chk("mrst_din_ready", 32'(din_ready), 32'd1);
        idle(4);
        chk("mrst_no_stale", 32'(dout_valid), 32'd0);
        send(8'h1C, 4'b0100, 1'b0);
        idle(4);
        chk("mrst_drained", 32'(sb.size()), 32'd0);

        // Other configurations
        side(0, 8'h14, 4'b0011, 1'b0, "hu_1p25");
        side(0, 8'h1C, 4'b0100, 1'b0, "hu_1p75");
        side(0, 8'hEC, 4'b1110, 1'b0, "hu_m1p25");
        side(0, 8'hBC, 4'b1000, 1'b0, "hu_m4p25");
        side(1, 8'h7F, 4'b0000, 1'b1, "wr_7f");
        side(1, 8'h3C, 4'b1000, 1'b1, "wr_3c");
        side(1, 8'h13, 4'b0010, 1'b0, "wr_13");
        side(2, 8'h0C, 4'b0000, 1'b0, "up_c");
        side(2, 8'h0F, 4'b0000, 1'b0, "up_f");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
